instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the opcode decoder: accepts symbolic instruction requests (kind plus register, shamt and immediate fields) and packs them into 32-bit MIPS words.
- Streams packed words into instruction memory at consecutive word addresses through a valid/ready write port.
- Used by the testbench and boot loader to build programs for the single-cycle CPU.
- Supports the same subset the CPU decodes: R-type ALU, sll, sllv, beq, bne, addi, lui, ori.

Parameters:
AW, 5, word-address width of the instruction memory port
DEPTH, 32, number of words in a program; must be at most 2^AW

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  reset; asynchronous, active-low
flush_i  input  1  synchronous restart of the program; clears pointers and error
req_valid_i  input  1  request present
req_ready_o  output  1  request accepted on the cycle where req_valid_i and req_ready_o are both 1
kind_i  input  3  0 = R-ALU, 1 = beq, 2 = bne, 3 = addi, 4 = lui, 5 = ori, 6 = sll, 7 = sllv
funct_i  input  6  funct field; used for R-ALU only
rs_i, rt_i, rd_i, shamt_i  input  5 each  instruction fields
imm_i  input  16  immediate, or branch offset/target
mem_valid_o  output  1  write word held on the port
mem_ready_i  input  1  memory accepts the write
mem_addr_o  output  AW  word address of the held word
mem_data_o  output  32  encoded instruction word
count_o  output  AW+1  number of words the memory has accepted
full_o  output  1  issue pointer has reached DEPTH
err_o  output  1  sticky illegal-request flag

Behaviour:
- Reset (rst_i = 0, asynchronous): all outputs and internal registers are 0, FSM goes to EMPTY. Reset mid-transfer drops any held word; no partial state survives.
- FSM states:
  - EMPTY: no word held.
  - HOLD: mem_valid_o = 1, word waiting for the memory.
  - FULL: issue pointer equals DEPTH and no word is held.
- Ready rule: req_ready_o = !full_o && (state == EMPTY || mem_ready_i). Combinational from state and mem_ready_i; never depends on req_valid_i.
- Accept:
  - Encoded word and mem_addr_o = issue_ptr are registered; mem_valid_o rises the next cycle (latency 1).
  - issue_ptr increments.
  - A request can be accepted in the same cycle the held word drains, giving back-to-back throughput of 1 word/cycle.
- Drain: on mem_valid_o && mem_ready_i, count_o increments. Next state:
  - HOLD if a new request is accepted in the same cycle;
  - otherwise FULL if issue_ptr == DEPTH;
  - otherwise EMPTY.
- Stability: while mem_valid_o = 1 and mem_ready_i = 0, mem_addr_o and mem_data_o are held stable.
- Encodings (op | rs | rt | rd | shamt | funct, or op | rs | rt | imm):
  - R-ALU: 000000, rs, rt, rd, 00000, funct_i.
  - sll: 000000, 00000, rt, rd, shamt, 000000.
  - sllv: 000000, rs, rt, rd, 00000, 000100.
  - beq: 000100, rs, rt, imm.
  - bne: 000101, rs, rt, imm.
  - addi: 001000, rs, rt, imm.
  - lui: 001111, 00000, rt, imm.
  - ori: 001101, rs, rt, imm.
- Illegal request: R-ALU with funct_i not in {0x20, 0x22, 0x24, 0x25, 0x2A}.
  - The request is accepted but no word is emitted, and issue_ptr does not advance.
  - err_o is set to 1 and stays set until flush_i or reset.
- FULL:
  - full_o = 1 and req_ready_o = 0.
  - Requests stay pending; none are dropped or wrapped.
  - The pointer never wraps; only flush_i or reset leaves FULL.
- flush_i priority:
  - flush_i beats accept and drain in the same cycle.
  - It clears issue_ptr, count_o, err_o and the held word; state goes to EMPTY.
  - req_ready_o is 0 while flush_i is 1.

Optional Feature:
- Macro: INSTR_ENCODER_BRANCH_REL_EN.
- Defined: for beq/bne, imm_i is an absolute target word index. The encoder emits offset = imm_i - (issue_ptr + 1), truncated to 16 bits, two's complement.
- Not defined: imm_i is copied verbatim into the immediate field for every kind.

Test Plan:
- Reset release, then addi with rs = 0, rt = 8, imm = 5 -> next cycle mem_valid_o = 1, mem_addr_o = 0, mem_data_o = 0x20080005. After mem_ready_i, count_o = 1.
- Back-to-back requests with mem_ready_i held at 1:
  - sll rt = 8, rd = 9, shamt = 2 -> 0x00084880 at address 0.
  - lui rt = 1, imm = 0x1234 -> 0x3C011234 at address 1.
  - add (funct 0x20) rs = 8, rt = 9, rd = 10 -> 0x01095020 at address 2.
  - Expect one word per cycle.
- Backpressure: mem_ready_i = 0 for 3 cycles with a new request pending -> req_ready_o = 0, address and data stable. Releasing mem_ready_i drains the held word and accepts the pending request in the same cycle.
- Illegal funct 0x3F -> err_o = 1, no mem_valid_o, issue_ptr unchanged. Then flush_i -> err_o = 0 and count_o = 0.
- DEPTH = 4: after 4 words, full_o = 1 and req_ready_o = 0 with req_valid_i = 1. Reset asserted while a word is held -> all outputs 0 immediately.
- With the macro defined: beq rs = 8, rt = 9 issued at address 3 with target 10 -> 0x11090006. Without the macro, the same request with imm = 10 -> 0x1109000A.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instruction requests into 32-bit words and streams
// them to instruction memory. Define INSTR_ENCODER_BRANCH_REL_EN to treat beq/bne imm as an absolute target.
module instr_encoder #(
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [2:0]    kind_i,
    input  logic [5:0]    funct_i,
    input  logic [4:0]    rs_i,
    input  logic [4:0]    rt_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    shamt_i,
    input  logic [15:0]   imm_i,
    output logic          mem_valid_o,
    input  logic          mem_ready_i,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_data_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        K_RALU = 3'd0,
        K_BEQ  = 3'd1,
        K_BNE  = 3'd2,
        K_ADDI = 3'd3,
        K_LUI  = 3'd4,
        K_ORI  = 3'd5,
        K_SLL  = 3'd6,
        K_SLLV = 3'd7
    } kind_e;

    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_P   = (AW+1)'(1);

    state_e        state_q, state_d;
    logic [AW:0]   issue_ptr_q, issue_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;

    logic          accept;
    logic          drain;
    logic          legal;
    logic [15:0]   br_imm;
    logic [31:0]   enc_word;

    assign req_ready_o = !flush_i && !full_q && (state_q == ST_EMPTY || mem_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign drain       = (state_q == ST_HOLD) && mem_ready_i;

    // Only the R-ALU kind can be illegal; every other kind has a fixed funct/opcode.
    assign legal = (kind_i != K_RALU) ||
                   (funct_i inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});

`ifdef INSTR_ENCODER_BRANCH_REL_EN
    // Branch offset is relative to the word after the branch itself.
    assign br_imm = imm_i - (16'(issue_ptr_q) + 16'd1);
`else
    assign br_imm = imm_i;
`endif

    always_comb begin
        // NOTE: a default on every path keeps this block free of inferred latches.
        enc_word = 32'h0;
        case (kind_e'(kind_i))
            K_RALU:  enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, funct_i};
            K_SLL:   enc_word = {6'b000000, 5'b00000, rt_i, rd_i, shamt_i, 6'b000000};
            K_SLLV:  enc_word = {6'b000000, rs_i, rt_i, rd_i, 5'b00000, 6'b000100};
            K_BEQ:   enc_word = {6'b000100, rs_i, rt_i, br_imm};
            K_BNE:   enc_word = {6'b000101, rs_i, rt_i, br_imm};
            K_ADDI:  enc_word = {6'b001000, rs_i, rt_i, imm_i};
            K_LUI:   enc_word = {6'b001111, 5'b00000, rt_i, imm_i};
            K_ORI:   enc_word = {6'b001101, rs_i, rt_i, imm_i};
            default: enc_word = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        issue_ptr_d = issue_ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        addr_d      = addr_q;
        data_d      = data_q;

        if (flush_i) begin
            state_d     = ST_EMPTY;
            issue_ptr_d = '0;
            count_d     = '0;
            err_d       = 1'b0;
            addr_d      = '0;
            data_d      = '0;
        end else begin
            if (drain) begin
                count_d = count_q + ONE_P;
            end
            if (accept && !legal) begin
                err_d = 1'b1;
            end
            if (accept && legal) begin
                state_d     = ST_HOLD;
                addr_d      = issue_ptr_q[AW-1:0];
                data_d      = enc_word;
                issue_ptr_d = issue_ptr_q + ONE_P;
            end else if (drain) begin
                state_d = (issue_ptr_q == DEPTH_P) ? ST_FULL : ST_EMPTY;
            end
        end

        full_d = (issue_ptr_d == DEPTH_P);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            issue_ptr_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            full_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            issue_ptr_q <= issue_ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            full_q      <= full_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    assign mem_valid_o = (state_q == ST_HOLD);
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = data_q;
    assign count_o     = count_q;
    assign full_o      = full_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed test-plan steps followed by
// randomized traffic against a word-level reference model.
module tb_instr_encoder;

    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk_i;
    logic          rst_i;
    logic          flush_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [2:0]    kind_i;
    logic [5:0]    funct_i;
    logic [4:0]    rs_i, rt_i, rd_i, shamt_i;
    logic [15:0]   imm_i;
    logic          mem_valid_o;
    logic          mem_ready_i;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_data_o;
    logic [AW:0]   count_o;
    logic          full_o;
    logic          err_o;

    instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .kind_i(kind_i), .funct_i(funct_i),
        .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .shamt_i(shamt_i), .imm_i(imm_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .count_o(count_o), .full_o(full_o), .err_o(err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int kind;
        int funct;
        int rs;
        int rt;
        int rd;
        int sh;
        int imm;
    } req_t;

    int checks   = 0;
    int failures = 0;

    // Reference state: words issued, words accepted by memory, and the one word in flight.
    int          m_ptr;
    int          m_cnt;
    bit          m_err;
    bit          m_valid;
    int          m_addr;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(int kind, int funct, int rs, int rt, int rd, int sh, int imm);
        req_t r;
        r.kind = kind; r.funct = funct; r.rs = rs; r.rt = rt;
        r.rd = rd; r.sh = sh; r.imm = imm;
        return r;
    endfunction

    function automatic bit ref_legal(req_t r);
        if (r.kind != 0) return 1'b1;
        return (r.funct == 32 || r.funct == 34 || r.funct == 36 ||
                r.funct == 37 || r.funct == 42);
    endfunction

    // Field packing by place value: op*2^26 + rs*2^21 + rt*2^16 + rd*2^11 + shamt*2^6 + funct.
    function automatic logic [31:0] ref_word(req_t r, int ptr);
        longint w;
        int     im;
        im = r.imm;
`ifdef INSTR_ENCODER_BRANCH_REL_EN
        if (r.kind == 1 || r.kind == 2) im = (r.imm - (ptr + 1)) & 65535;
`endif
        case (r.kind)
            0: w = r.rs * 2**21 + r.rt * 2**16 + r.rd * 2**11 + r.funct;
            1: w = 4  * 2**26 + r.rs * 2**21 + r.rt * 2**16 + im;
            2: w = 5  * 2**26 + r.rs * 2**21 + r.rt * 2**16 + im;
            3: w = 8  * 2**26 + r.rs * 2**21 + r.rt * 2**16 + r.imm;
            4: w = 15 * 2**26 + r.rt * 2**16 + r.imm;
            5: w = 13 * 2**26 + r.rs * 2**21 + r.rt * 2**16 + r.imm;
            6: w = r.rt * 2**16 + r.rd * 2**11 + r.sh * 2**6;
            default: w = r.rs * 2**21 + r.rt * 2**16 + r.rd * 2**11 + 4;
        endcase
        return w[31:0];
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_err = 0; m_valid = 0; m_addr = 0; m_data = '0;
    endtask

    // One clock: drive on the falling edge, compare against the model, then advance the model.
    task automatic cycle(input bit v, input req_t r, input bit mr, input bit fl);
        bit exp_ready;
        @(negedge clk_i);
        req_valid_i = v;
        kind_i      = 3'(r.kind);
        funct_i     = 6'(r.funct);
        rs_i        = 5'(r.rs);
        rt_i        = 5'(r.rt);
        rd_i        = 5'(r.rd);
        shamt_i     = 5'(r.sh);
        imm_i       = 16'(r.imm);
        mem_ready_i = mr;
        flush_i     = fl;
        #1;
        exp_ready = !fl && (m_ptr != DEPTH) && (!m_valid || mr);
        check("req_ready", 32'(req_ready_o), 32'(exp_ready));
        check("mem_valid", 32'(mem_valid_o), 32'(m_valid));
        if (m_valid) begin
            check("mem_addr", 32'(mem_addr_o), 32'(m_addr));
            check("mem_data", mem_data_o, m_data);
        end
        check("count", 32'(count_o), 32'(m_cnt));
        check("full", 32'(full_o), 32'(m_ptr == DEPTH));
        check("err", 32'(err_o), 32'(m_err));

        if (fl) begin
            model_reset();
        end else begin
            if (m_valid && mr) begin
                m_cnt++;
                m_valid = 0;
            end
            if (v && exp_ready) begin
                if (ref_legal(r)) begin
                    m_valid = 1;
                    m_addr  = m_ptr;
                    m_data  = ref_word(r, m_ptr);
                    m_ptr++;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    req_t r0;

    task automatic idle(input bit mr);
        cycle(1'b0, r0, mr, 1'b0);
    endtask

    task automatic do_flush();
        cycle(1'b0, r0, 1'b1, 1'b1);
    endtask

    initial begin
        req_t   rq;
        int     legal_f[5];
        bit     v, mr, fl;
        logic [31:0] exp_br;

        legal_f = '{32, 34, 36, 37, 42};
        r0 = mk(0, 32, 0, 0, 0, 0, 0);
        rst_i = 1'b0; flush_i = 0; req_valid_i = 0; mem_ready_i = 0;
        kind_i = 0; funct_i = 0; rs_i = 0; rt_i = 0; rd_i = 0; shamt_i = 0; imm_i = 0;

        @(negedge clk_i); #1;
        check("rst_valid", 32'(mem_valid_o), 32'h0);
        check("rst_addr", 32'(mem_addr_o), 32'h0);
        check("rst_data", mem_data_o, 32'h0);
        check("rst_count", 32'(count_o), 32'h0);
        check("rst_full", 32'(full_o), 32'h0);
        check("rst_err", 32'(err_o), 32'h0);
        model_reset();
        rst_i = 1'b1;

        // Single addi, latency 1, then drain.
        cycle(1, mk(3, 0, 0, 8, 0, 0, 5), 0, 0);
        idle(0);
        check("addi_valid", 32'(mem_valid_o), 32'h1);
        check("addi_addr", 32'(mem_addr_o), 32'h0);
        check("addi_data", mem_data_o, 32'h20080005);
        idle(1);
        idle(1);
        check("addi_count", 32'(count_o), 32'h1);

        // Back-to-back at one word per cycle.
        do_flush();
        cycle(1, mk(6, 0, 0, 8, 9, 2, 0), 1, 0);
        cycle(1, mk(4, 0, 0, 1, 0, 0, 16'h1234), 1, 0);
        check("b2b_sll_addr", 32'(mem_addr_o), 32'h0);
        check("b2b_sll_data", mem_data_o, 32'h00084880);
        cycle(1, mk(0, 32, 8, 9, 10, 0, 0), 1, 0);
        check("b2b_lui_addr", 32'(mem_addr_o), 32'h1);
        check("b2b_lui_data", mem_data_o, 32'h3C011234);
        idle(1);
        check("b2b_add_addr", 32'(mem_addr_o), 32'h2);
        check("b2b_add_data", mem_data_o, 32'h01095020);
        idle(1);
        check("b2b_count", 32'(count_o), 32'h3);

        // Backpressure with a pending request.
        do_flush();
        cycle(1, mk(3, 0, 1, 2, 0, 0, 7), 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, mk(5, 0, 3, 4, 0, 0, 16'h00FF), 0, 0);
            check("bp_ready", 32'(req_ready_o), 32'h0);
            check("bp_addr", 32'(mem_addr_o), 32'h0);
            check("bp_data", mem_data_o, 32'h20220007);
        end
        cycle(1, mk(5, 0, 3, 4, 0, 0, 16'h00FF), 1, 0);
        idle(1);
        check("bp_next_addr", 32'(mem_addr_o), 32'h1);
        check("bp_next_data", mem_data_o, 32'h346400FF);
        idle(1);

        // Illegal funct: accepted, nothing emitted, pointer held, sticky error.
        do_flush();
        cycle(1, mk(0, 63, 1, 2, 3, 0, 0), 1, 0);
        idle(1);
        check("ill_err", 32'(err_o), 32'h1);
        check("ill_valid", 32'(mem_valid_o), 32'h0);
        cycle(1, mk(3, 0, 0, 8, 0, 0, 5), 1, 0);
        idle(1);
        check("ill_ptr_addr", 32'(mem_addr_o), 32'h0);
        check("ill_err_sticky", 32'(err_o), 32'h1);
        do_flush();
        idle(1);
        check("flush_err", 32'(err_o), 32'h0);
        check("flush_count", 32'(count_o), 32'h0);

        // Fill to DEPTH; further requests stay pending.
        for (int i = 0; i < DEPTH; i++) cycle(1, mk(3, 0, 0, i, 0, 0, i), 1, 0);
        idle(1);
        cycle(1, mk(3, 0, 0, 1, 0, 0, 1), 1, 0);
        cycle(1, mk(3, 0, 0, 1, 0, 0, 1), 1, 0);
        check("full_flag", 32'(full_o), 32'h1);
        check("full_ready", 32'(req_ready_o), 32'h0);
        check("full_count", 32'(count_o), 32'(DEPTH));

        // Asynchronous reset while a word is held.
        do_flush();
        cycle(1, mk(3, 0, 0, 8, 0, 0, 5), 1, 0);
        cycle(1, mk(3, 0, 0, 9, 0, 0, 6), 1, 0);
        idle(0);
        check("pre_rst_valid", 32'(mem_valid_o), 32'h1);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        check("arst_valid", 32'(mem_valid_o), 32'h0);
        check("arst_addr", 32'(mem_addr_o), 32'h0);
        check("arst_data", mem_data_o, 32'h0);
        check("arst_count", 32'(count_o), 32'h0);
        check("arst_full", 32'(full_o), 32'h0);
        check("arst_err", 32'(err_o), 32'h0);
        model_reset();
        @(negedge clk_i); #1 rst_i = 1'b1;

        // Branch issued at address 3.
        do_flush();
        for (int i = 0; i < 3; i++) cycle(1, mk(3, 0, 0, 1, 0, 0, i), 1, 0);
        cycle(1, mk(1, 0, 8, 9, 0, 0, 10), 1, 0);
        idle(1);
`ifdef INSTR_ENCODER_BRANCH_REL_EN
        exp_br = 32'h11090006;
`else
        exp_br = 32'h1109000A;
`endif
        check("beq_addr", 32'(mem_addr_o), 32'h3);
        check("beq_data", mem_data_o, exp_br);
        idle(1);

        // Randomized traffic.
        do_flush();
        for (int i = 0; i < 400; i++) begin
            rq.kind  = $urandom_range(0, 7);
            rq.funct = ($urandom_range(0, 9) == 0) ? 63 : legal_f[$urandom_range(0, 4)];
            rq.rs    = $urandom_range(0, 31);
            rq.rt    = $urandom_range(0, 31);
            rq.rd    = $urandom_range(0, 31);
            rq.sh    = $urandom_range(0, 31);
            rq.imm   = $urandom_range(0, 65535);
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            fl = ((m_ptr == DEPTH) && !m_valid && ($urandom_range(0, 1) == 1)) ||
                 ($urandom_range(0, 39) == 0);
            cycle(v, rq, mr, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
